// File: rtl/niosii_irq_ctrl.sv
// Avalon-MM interrupt controller: rising-edge latched pending bits, mask and global
// enable, a single CPU interrupt with a programmable minimum low gap, and an event counter.
module niosii_irq_ctrl #(
  parameter int NUM_IRQ   = 4,
  parameter int HOLDOFF_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq_out
);

  typedef enum logic [1:0] {IDLE, ASSERTED, HOLD} state_t;

  state_t                 r_state;
  logic [NUM_IRQ-1:0]     r_pending;
  logic [NUM_IRQ-1:0]     r_mask;
  logic [NUM_IRQ-1:0]     r_irq_in_d;
  logic                   r_enable;
  logic [HOLDOFF_W-1:0]   r_holdoff;
  logic [HOLDOFF_W-1:0]   r_cnt;
  logic [15:0]            r_event_count;
  logic [15:0]            r_readdata;
  logic                   r_irq_out;

  logic                   w_wr;
  logic [NUM_IRQ-1:0]     w_rise;
  logic [NUM_IRQ-1:0]     w_w1c;
  logic [NUM_IRQ-1:0]     w_act;
  logic                   w_req;
  logic [3:0]             w_low_idx;
  logic [15:0]            w_rd_mux;

  assign w_wr   = chipselect && !write_n;
  assign w_rise = irq_in & ~r_irq_in_d;
  assign w_w1c  = (w_wr && address == 3'd0) ? writedata[NUM_IRQ-1:0] : '0;
  assign w_act  = r_pending & r_mask;
  assign w_req  = r_enable && (|w_act);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (w_act[i]) w_low_idx = 4'(i);
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      3'd0: w_rd_mux = 16'(r_pending);
      3'd1: w_rd_mux = 16'(r_mask);
      3'd2: w_rd_mux = {|w_act, 11'd0, w_low_idx};
      3'd3: w_rd_mux = 16'(r_holdoff);
      3'd4: w_rd_mux = r_event_count;
      3'd5: w_rd_mux = {14'd0, r_state == HOLD, r_enable};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending     <= '0;
      r_mask        <= '0;
      r_irq_in_d    <= '0;
      r_enable      <= 1'b0;
      r_holdoff     <= '0;
      r_event_count <= '0;
      r_readdata    <= '0;
    end else begin
      r_irq_in_d <= irq_in;
      r_pending  <= (r_pending & ~w_w1c) | w_rise;
      r_readdata <= w_rd_mux;
      if (w_wr && address == 3'd1) r_mask    <= writedata[NUM_IRQ-1:0];
      if (w_wr && address == 3'd3) r_holdoff <= writedata[HOLDOFF_W-1:0];
      if (w_wr && address == 3'd5) r_enable  <= writedata[0];
      // A clear write beats a same-cycle increment.
      if (w_wr && address == 3'd4)
        r_event_count <= '0;
      else if (|w_rise && r_event_count != 16'hFFFF)
        r_event_count <= r_event_count + 16'd1;
    end
  end

  // irq_out is registered alongside the state so it always equals (state == ASSERTED).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_irq_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state   <= ASSERTED;
            r_irq_out <= 1'b1;
          end else begin
            r_irq_out <= 1'b0;
          end
        end
        ASSERTED: begin
          if (!w_req) begin
            r_irq_out <= 1'b0;
            if (r_holdoff == '0) begin
              r_state <= IDLE;
            end else begin
              r_cnt   <= r_holdoff;
              r_state <= HOLD;
            end
          end else begin
            r_irq_out <= 1'b1;
          end
        end
        HOLD: begin
          r_irq_out <= 1'b0;
          r_cnt     <= r_cnt - HOLDOFF_W'(1);
          if (r_cnt == HOLDOFF_W'(1)) r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_irq_out <= 1'b0;
        end
      endcase
    end
  end

  assign readdata = r_readdata;
  assign irq_out  = r_irq_out;

endmodule

// File: tb/tb_niosii_irq_ctrl.sv
// Bench for niosii_irq_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a behavioural model.
module tb_niosii_irq_ctrl;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = '0;
  logic [N-1:0]  irq_in = '0;
  logic [15:0]   readdata;
  logic          irq_out;

  int checks = 0;
  int errors = 0;
  int preset_seq = 0;

  always #5 clk = ~clk;

  niosii_irq_ctrl #(.NUM_IRQ(N), .HOLDOFF_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .irq_in(irq_in),
    .readdata(readdata), .irq_out(irq_out)
  );

  // Behavioural model: the interrupt line is "allowed to re-assert" only once a
  // block countdown of holdoff cycles after each fall has expired.
  logic [N-1:0] m_pend, m_mask, m_prev, m_act, m_rise, m_w1c;
  logic         m_en, m_irq, m_req, m_wr;
  int           m_hold, m_cnt, m_block, m_low, m_seen;
  logic [15:0]  m_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_en = 1'b0; m_irq = 1'b0;
      m_hold = 0; m_cnt = 0; m_block = 0; m_rd = '0; m_seen = preset_seq;
    end else begin
      if (m_seen != preset_seq) begin
        m_cnt  = 65534;
        m_seen = preset_seq;
      end
      m_act = m_pend & m_mask;
      m_req = m_en && (m_act != '0);
      m_low = 0;
      for (int i = N - 1; i >= 0; i--) if (m_act[i]) m_low = i;
      case (address)
        3'd0: m_rd = {12'd0, m_pend};
        3'd1: m_rd = {12'd0, m_mask};
        3'd2: m_rd = (m_act != '0) ? (16'h8000 | 16'(m_low)) : 16'h0000;
        3'd3: m_rd = 16'(m_hold);
        3'd4: m_rd = 16'(m_cnt);
        3'd5: m_rd = {14'd0, m_block > 0, m_en};
        default: m_rd = 16'h0000;
      endcase
      if (m_irq) begin
        if (!m_req) begin
          m_irq   = 1'b0;
          m_block = m_hold;
        end
      end else if (m_block > 0) begin
        m_block = m_block - 1;
      end else begin
        m_irq = m_req;
      end
      m_wr   = chipselect && !write_n;
      m_rise = irq_in & ~m_prev;
      m_prev = irq_in;
      m_w1c  = (m_wr && address == 3'd0) ? writedata[N-1:0] : '0;
      m_pend = (m_pend & ~m_w1c) | m_rise;
      if (m_wr && address == 3'd1) m_mask = writedata[N-1:0];
      if (m_wr && address == 3'd3) m_hold = int'(writedata);
      if (m_wr && address == 3'd5) m_en = writedata[0];
      if (m_wr && address == 3'd4) m_cnt = 0;
      else if (m_rise != '0 && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("model_readdata", 32'(readdata), 32'(m_rd));
    chk("model_irq_out", 32'(irq_out), 32'(m_irq));
  end

  // All tasks start and end 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr=%0d data=0x%04h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    address = a;
    @(posedge clk); #1;
    chk(name, 32'(readdata), 32'(exp));
    $display("read  addr=%0d data=0x%04h expect=0x%04h", a, readdata, exp);
    #1;
  endtask

  initial begin
    int low;
    step(3);
    reset_n = 1'b1;
    step(1);
    for (int a = 0; a < 6; a++) rd(3'(a), 16'h0000, "reset_read");
    chk("reset_irq_out", 32'(irq_out), 32'd0);

    // Single timer pulse.
    wr(3'd1, 16'h0001);
    wr(3'd5, 16'h0001);
    irq_in = 4'b0001;
    step(1);
    irq_in = 4'b0000;
    chk("irq_one_cycle_after_edge", 32'(irq_out), 32'd0);
    step(1);
    chk("irq_two_cycles_after_edge", 32'(irq_out), 32'd1);
    rd(3'd0, 16'h0001, "pending_timer");
    rd(3'd2, 16'h8000, "active_timer");
    rd(3'd4, 16'h0001, "event_count_one");
    wr(3'd0, 16'h0001);

    // Priority and W1C.
    wr(3'd1, 16'h000F);
    irq_in = 4'b1010;
    step(1);
    irq_in = 4'b0000;
    step(1);
    rd(3'd0, 16'h000A, "pending_0a");
    rd(3'd2, 16'h8001, "active_idx1");
    wr(3'd0, 16'h0002);
    rd(3'd2, 16'h8003, "active_idx3");
    wr(3'd0, 16'h0008);
    chk("irq_still_high_at_clear", 32'(irq_out), 32'd1);
    step(1);
    chk("irq_falls_after_clear", 32'(irq_out), 32'd0);
    rd(3'd2, 16'h0000, "active_none");

    // Hold-off gap of holdoff+1 cycles, unaffected by a mid-hold reload write.
    wr(3'd3, 16'd5);
    irq_in = 4'b0010;
    step(1);
    irq_in = 4'b0000;
    step(2);
    chk("irq_before_gap", 32'(irq_out), 32'd1);
    wr(3'd0, 16'h0002);
    irq_in = 4'b0100;
    wr(3'd3, 16'd2);
    chk("gap_start_low", 32'(irq_out), 32'd0);
    low = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (irq_out) break;
      low++;
    end
    #1;
    chk("holdoff_gap_cycles", 32'(low), 32'd6);
    irq_in = 4'b0000;
    step(1);

    // Same-cycle set beats clear; clear beats increment.
    irq_in = 4'b0010;
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0006, "set_wins_over_clear");
    irq_in = 4'b1010;
    wr(3'd4, 16'h0000);
    rd(3'd4, 16'h0000, "clear_wins_over_inc");
    irq_in = 4'b0000;
    step(1);

    // Saturation.
    address = 3'd0;
    force dut.r_event_count = 16'hFFFE;
    preset_seq++;
    @(negedge clk);
    release dut.r_event_count;
    step(1);
    for (int i = 0; i < 3; i++) begin
      irq_in = 4'b0001; step(1);
      irq_in = 4'b0000; step(1);
    end
    rd(3'd4, 16'hFFFF, "event_count_saturates");

    // Asynchronous reset in the middle of a hold-off.
    wr(3'd3, 16'd20);
    rd(3'd2, 16'h8000, "active_before_hold");
    wr(3'd0, 16'h000F);
    step(3);
    rd(3'd5, 16'h0003, "control_in_hold");
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_irq_out", 32'(irq_out), 32'd0);
    chk("async_reset_readdata", 32'(readdata), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    for (int a = 0; a < 6; a++) rd(3'(a), 16'h0000, "post_reset_read");

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] a;
      a = 3'($urandom_range(0, 7));
      address = a;
      chipselect = 1'b0; write_n = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        chipselect = ($urandom_range(0, 3) != 0);
        write_n = 1'b0;
        writedata = (a == 3'd3) ? 16'($urandom_range(0, 7)) : 16'($urandom);
        if (a == 3'd5 && $urandom_range(0, 3) != 0) writedata[0] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
      step(1);
    end
    chipselect = 1'b0; write_n = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
